// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised loadable up/down counter with step, wrap/saturate and terminal-count flag
module updown_counter_param #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 2,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              en,
    input  logic              inc,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic [2:0]        state,
    output logic              tc,
    output logic              at_max,
    output logic              at_min
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_DEC  = 3'b011,
        ST_HOLD = 3'b100
    } state_t;

    localparam int EW = WIDTH + 1;

    logic [2:0]       state_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // One extra bit on both operands exposes carry (sum) and borrow (diff).
    assign step_ext = EW'(step);
    assign sum      = {1'b0, count} + step_ext;
    assign diff     = {1'b0, count} - step_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            count <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            tc    <= tc_d;
        end
    end

    always_comb begin
        state_d = state;
        count_d = count;
        tc_d    = 1'b0;

        case (state)
            ST_IDLE, ST_LOAD, ST_INC, ST_DEC, ST_HOLD: begin
                if (load)
                    state_d = ST_LOAD;
                else if (!en)
                    state_d = ST_HOLD;
                else if (inc)
                    state_d = ST_INC;
                else
                    state_d = ST_DEC;
            end
            default: state_d = ST_IDLE;
        endcase

        // The datapath action follows the state being entered, not the current one.
        case (state_d)
            ST_LOAD: count_d = d_in;
            ST_INC: begin
                if (sum[WIDTH]) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? '1 : sum[WIDTH-1:0];
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end
            ST_DEC: begin
                if (diff[WIDTH]) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE != 0) ? '0 : diff[WIDTH-1:0];
                end else begin
                    count_d = diff[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    assign at_max = &count;
    assign at_min = ~|count;

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised, loadable up/down counter with an explicit registered control FSM (IDLE/LOAD/INC/DEC/HOLD), programmable step size, selectable wrap or saturate overflow handling, and a terminal-count event flag. It replaces the fixed 8-bit up/down loadable counter in the counter library. It serves as the general-purpose event/address counter for datapaths that need widths other than 8, multi-count steps, or clamping at the range limits.

## Interface
- WIDTH, 8: counter width in bits (≥2).
- STEP_W, 2: width of the step input (1 ≤ STEP_W ≤ WIDTH).
- SATURATE, 0: overflow mode. 0 = modulo 2^WIDTH wrap; 1 = clamp at 0 / 2^WIDTH−1.

- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  load request; highest priority.
- en  input  1  count enable. 0 = hold (when load=0).
- inc  input  1  direction. 1 = up, 0 = down.
- d_in  input  WIDTH  value captured on load.
- step  input  STEP_W  unsigned increment/decrement amount, sampled every counting cycle.
- count  output  WIDTH  registered counter value.
- state  output  3  registered FSM state.
- tc  output  1  registered terminal-count flag: 1 for exactly the cycle after a count that wrapped or clamped.
- at_max  output  1  combinational: count == 2^WIDTH−1.
- at_min  output  1  combinational: count == 0.

## Operation
- FSM encoding: IDLE=3'b000, LOAD=3'b001, INC=3'b010, DEC=3'b011, HOLD=3'b100. Codes 101–111 are illegal.
- Next-state decision, identical from every legal state, evaluated in priority order:
  - load=1 → LOAD.
  - en=0 → HOLD.
  - inc=1 → INC.
  - else → DEC.
- IDLE is entered only by reset. It is never re-entered by the FSM.
- Illegal state → next state IDLE, with count unchanged and tc=0.
- The action is tied to the state being entered. On each rising edge, state ← next_state and count is updated per next_state:
  - LOAD: count ← d_in; tc ← 0.
  - HOLD: count unchanged; tc ← 0.
  - INC: sum = count + step, computed WIDTH+1 bits wide.
    - If sum[WIDTH]=1: SATURATE=0 → count ← sum[WIDTH-1:0]; SATURATE=1 → count ← all ones. tc ← 1 in both cases.
    - Otherwise: count ← sum; tc ← 0.
  - DEC: diff = count − step, computed WIDTH+1 bits wide.
    - If borrow (step > count): SATURATE=0 → count ← diff[WIDTH-1:0]; SATURATE=1 → count ← 0. tc ← 1 in both cases.
    - Otherwise: count ← diff; tc ← 0.
- step=0 in INC or DEC: count unchanged, tc=0. The state still reports INC/DEC.
- Saturate mode at a limit: INC at max (or DEC at 0) with step≠0 keeps count at the limit and asserts tc every such cycle.
- load with en=0: load wins (LOAD).
- load, en and inc all high: LOAD.
- at_max and at_min are decoded from the registered count only. They never depend on inputs in the same cycle.

## Timing
- Reset (reset_n=0, asynchronous, any time including mid-count):
  - state=IDLE, count=0, tc=0, so at_min=1 and at_max=0.
  - The effect is immediate, without waiting for clk.
  - Release is synchronous in effect: the first rising edge with reset_n=1 applies the normal next-state decision.
- Latency: inputs sampled at edge N appear on state/count/tc immediately after edge N (1-cycle register latency). No pipelining and no back-pressure.
- Sustained counting: one update per clock. Changing inc flips direction with no dead cycle.
- tc is high for one cycle per overflow event. It stays high across consecutive cycles if consecutive counts overflow.
- at_max and at_min settle combinationally within the same cycle as count.

## Test plan
- Reset: assert reset_n=0 mid-count with count=8'h5A, between edges → count=0, state=IDLE, tc=0 before the next edge. Release, load=0, en=1, inc=1, step=1 → count=1, state=INC after the first edge.
- Load priority: load=1, en=0, inc=1, d_in=8'hC3 → count=8'hC3, state=LOAD. Then load=0, en=0 → state=HOLD, count stays 8'hC3 over 3 cycles.
- Wrap up (SATURATE=0): load 8'hFE, then inc=1, en=1, step=3 → count=8'h01, tc=1 for one cycle. A next step=1 → count=8'h02, tc=0.
- Wrap down (SATURATE=0): load 8'h01, inc=0, step=2 → count=8'hFF, tc=1, at_max=1.
- Saturate (SATURATE=1): load 8'hFD, inc=1, step=3 for 3 cycles → count=8'hFF on all three, tc=1 on all three. Then inc=0, step=0 → count=8'hFF, tc=0, state=DEC.
- Width/step parameters: WIDTH=12, STEP_W=4. Load 12'h000, DEC with step=4'hF → count=12'hFF1, tc=1, and at_min is 1 only before the decrement.
